pc_stepper: RTL and testbench



---
 rtl/pc_stepper_pkg.sv | 31 +++
 rtl/ret_stack.sv | 53 +++++
 rtl/pc_stepper.sv | 88 ++++++++
 tb/tb_pc_stepper.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_stepper_pkg.sv
// Shared types for the program-counter sequencer: the per-edge operation
// and the priority decode from the raw request lines.
package pc_stepper_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_STEP = 3'd4
  } op_e;

  // Exactly one op per edge; lower-priority requests in the same cycle are dropped.
  function automatic op_e decode_op(
    input logic stall,
    input logic load,
    input logic call,
    input logic ret,
    input logic step
  );
    op_e op;
    if (stall)     op = OP_HOLD;
    else if (load) op = OP_LOAD;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (step) op = OP_STEP;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Small LIFO of return addresses. Push while full and pop while empty are
// ignored here; the caller owns error reporting.
module ret_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  assign wr_idx  = IW'(count);
  assign top_idx = IW'(count - CW'(1));
  // Entries at or above count are stale; top is only meaningful when !empty.
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  // Contents are not reset; only the pointer decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stepper.sv
// Program-counter sequencer: PC register, constant-stride successor,
// absolute jumps, stall, and a hardware return-address stack with sticky err.
module pc_stepper
  import pc_stepper_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      STRIDE     = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      DEPTH      = 4,
  localparam int unsigned     CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             step,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [CW-1:0]    depth_cnt,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             err
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STRIDE);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

  op_e              op;
  logic [WIDTH-1:0] target_aligned;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] pc_next;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             underflow;

  assign op             = decode_op(stall, load, call, ret, step);
  assign pc_plus        = pc + STEP_W;
  assign target_aligned = target & ALIGN_MASK;

  // A call while full still jumps; only the push is lost.
  assign push      = (op == OP_CALL) && !stk_full;
  assign pop       = (op == OP_RET) && !stk_empty;
  assign overflow  = (op == OP_CALL) && stk_full;
  assign underflow = (op == OP_RET) && stk_empty;

  always_comb begin
    pc_next = pc;
    unique case (op)
      OP_LOAD: pc_next = target_aligned;
      OP_CALL: pc_next = target_aligned;
      OP_RET:  pc_next = stk_empty ? pc : stack_top;
      OP_STEP: pc_next = pc_plus;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_ADDR;
      err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (overflow || underflow) begin
        err <= 1'b1;
      end
    end
  end

  ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ret_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (pc_plus),
    .top  (stack_top),
    .count(depth_cnt),
    .full (stk_full),
    .empty(stk_empty)
  );

endmodule

// File: tb/tb_pc_stepper.sv
// Directed bench for pc_stepper: a default 32-bit instance and a narrow
// 8-bit, 2-deep instance, driven from hand-computed vector tables.
module tb_pc_stepper;

  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_STEP  = 5'b00001;
  localparam logic [4:0] R_RET   = 5'b00010;
  localparam logic [4:0] R_CALL  = 5'b00100;
  localparam logic [4:0] R_LOAD  = 5'b01000;
  localparam logic [4:0] R_STALL = 5'b10000;

  typedef struct {
    logic [4:0]  req;     // {stall, load, call, ret, step}
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_plus;
    logic [3:0]  exp_depth;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: WIDTH=32, STRIDE=4, DEPTH=4
  logic        a_stall = 0, a_step = 0, a_load = 0, a_call = 0, a_ret = 0;
  logic [31:0] a_target = '0;
  logic [31:0] a_pc, a_pc_plus;
  logic [2:0]  a_depth;
  logic        a_empty, a_full, a_err;

  // Narrow instance: WIDTH=8, STRIDE=4, DEPTH=2
  logic        b_stall = 0, b_step = 0, b_load = 0, b_call = 0, b_ret = 0;
  logic [7:0]  b_target = '0;
  logic [7:0]  b_pc, b_pc_plus;
  logic [1:0]  b_depth;
  logic        b_empty, b_full, b_err;

  pc_stepper u_dut_a (
    .clk(clk), .rst_n(rst_n), .stall(a_stall), .step(a_step), .load(a_load),
    .call(a_call), .ret(a_ret), .target(a_target), .pc(a_pc), .pc_plus(a_pc_plus),
    .depth_cnt(a_depth), .stk_empty(a_empty), .stk_full(a_full), .err(a_err)
  );

  pc_stepper #(.WIDTH(8), .STRIDE(4), .RESET_ADDR(8'h00), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .stall(b_stall), .step(b_step), .load(b_load),
    .call(b_call), .ret(b_ret), .target(b_target), .pc(b_pc), .pc_plus(b_pc_plus),
    .depth_cnt(b_depth), .stk_empty(b_empty), .stk_full(b_full), .err(b_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] req, input logic [31:0] target,
                              input logic [31:0] exp_pc, input logic [31:0] exp_plus,
                              input logic [3:0] exp_depth, input logic exp_err);
    vec_t v;
    v.req = req; v.target = target; v.exp_pc = exp_pc; v.exp_plus = exp_plus;
    v.exp_depth = exp_depth; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check_a(input string tag, input vec_t v);
    check({tag, " pc"}, a_pc, v.exp_pc);
    check({tag, " pc_plus"}, a_pc_plus, v.exp_plus);
    check({tag, " depth"}, 32'(a_depth), 32'(v.exp_depth));
    check({tag, " empty"}, 32'(a_empty), 32'(v.exp_depth == 0));
    check({tag, " full"}, 32'(a_full), 32'(v.exp_depth == 4));
    check({tag, " err"}, 32'(a_err), 32'(v.exp_err));
  endtask

  task automatic check_b(input string tag, input vec_t v);
    check({tag, " pc"}, 32'(b_pc), v.exp_pc);
    check({tag, " pc_plus"}, 32'(b_pc_plus), v.exp_plus);
    check({tag, " depth"}, 32'(b_depth), 32'(v.exp_depth));
    check({tag, " empty"}, 32'(b_empty), 32'(v.exp_depth == 0));
    check({tag, " full"}, 32'(b_full), 32'(v.exp_depth == 2));
    check({tag, " err"}, 32'(b_err), 32'(v.exp_err));
  endtask

  // Drive one request for one edge, then compare just after the edge.
  task automatic run_vec(input bit sel_b, input int idx, input vec_t v);
    if (!sel_b) begin
      {a_stall, a_load, a_call, a_ret, a_step} = v.req;
      a_target = v.target;
    end else begin
      {b_stall, b_load, b_call, b_ret, b_step} = v.req;
      b_target = v.target[7:0];
    end
    @(posedge clk);
    #1;
    if (!sel_b) check_a($sformatf("a[%0d]", idx), v);
    else        check_b($sformatf("b[%0d]", idx), v);
    {a_stall, a_load, a_call, a_ret, a_step} = R_NONE;
    {b_stall, b_load, b_call, b_ret, b_step} = R_NONE;
  endtask

  vec_t va[27];
  vec_t vb[10];

  initial begin
    // Default instance: stepping, call/ret, stall, priority, alignment, wrap.
    va[0]  = mk(R_STEP,           32'h0,        32'h4,        32'h8,        0, 0);
    va[1]  = mk(R_STEP,           32'h0,        32'h8,        32'hC,        0, 0);
    va[2]  = mk(R_STEP,           32'h0,        32'hC,        32'h10,       0, 0);
    va[3]  = mk(R_LOAD,           32'h10,       32'h10,       32'h14,       0, 0);
    va[4]  = mk(R_CALL,           32'h100,      32'h100,      32'h104,      1, 0);
    va[5]  = mk(R_STEP,           32'h0,        32'h104,      32'h108,      1, 0);
    va[6]  = mk(R_STEP,           32'h0,        32'h108,      32'h10C,      1, 0);
    va[7]  = mk(R_RET,            32'h0,        32'h14,       32'h18,       0, 0);
    va[8]  = mk(R_STALL | R_LOAD, 32'h200,      32'h14,       32'h18,       0, 0);
    va[9]  = mk(R_STALL | R_STEP, 32'h0,        32'h14,       32'h18,       0, 0);
    va[10] = mk(R_LOAD | R_STEP,  32'h40,       32'h40,       32'h44,       0, 0);
    va[11] = mk(R_LOAD,           32'h43,       32'h40,       32'h44,       0, 0);
    va[12] = mk(R_CALL,           32'h80,       32'h80,       32'h84,       1, 0);
    va[13] = mk(R_RET,            32'h0,        32'h44,       32'h48,       0, 0);
    va[14] = mk(R_STALL | R_CALL, 32'h300,      32'h44,       32'h48,       0, 0);
    va[15] = mk(R_STALL | R_RET,  32'h0,        32'h44,       32'h48,       0, 0);
    va[16] = mk(R_CALL,           32'h1000,     32'h1000,     32'h1004,     1, 0);
    va[17] = mk(R_CALL,           32'h2000,     32'h2000,     32'h2004,     2, 0);
    va[18] = mk(R_CALL | R_STEP,  32'h3000,     32'h3000,     32'h3004,     3, 0);
    va[19] = mk(R_RET | R_STEP,   32'h0,        32'h2004,     32'h2008,     2, 0);
    va[20] = mk(R_RET,            32'h0,        32'h1004,     32'h1008,     1, 0);
    va[21] = mk(R_RET,            32'h0,        32'h48,       32'h4C,       0, 0);
    va[22] = mk(R_NONE,           32'h0,        32'h48,       32'h4C,       0, 0);
    va[23] = mk(R_RET,            32'h0,        32'h48,       32'h4C,       0, 1);
    va[24] = mk(R_STALL | R_LOAD, 32'h0,        32'h48,       32'h4C,       0, 1);
    va[25] = mk(R_LOAD,           32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        0, 1);
    va[26] = mk(R_STEP,           32'h0,        32'h0,        32'h4,        0, 1);

    // Narrow instance: 8-bit wrap, overflow on third call, underflow hold.
    vb[0] = mk(R_LOAD, 32'hFD, 32'hFC, 32'h00, 0, 0);
    vb[1] = mk(R_STEP, 32'h00, 32'h00, 32'h04, 0, 0);
    vb[2] = mk(R_CALL, 32'h20, 32'h20, 32'h24, 1, 0);
    vb[3] = mk(R_CALL, 32'h40, 32'h40, 32'h44, 2, 0);
    vb[4] = mk(R_CALL, 32'h63, 32'h60, 32'h64, 2, 1);
    vb[5] = mk(R_RET,  32'h00, 32'h24, 32'h28, 1, 1);
    vb[6] = mk(R_RET,  32'h00, 32'h04, 32'h08, 0, 1);
    vb[7] = mk(R_RET,  32'h00, 32'h04, 32'h08, 0, 1);
    vb[8] = mk(R_CALL, 32'h80, 32'h80, 32'h84, 1, 1);
    vb[9] = mk(R_CALL, 32'h90, 32'h90, 32'h94, 2, 1);

    // Reset state, sampled while reset is still held.
    #12;
    check_a("reset_a", mk(R_NONE, 32'h0, 32'h0, 32'h4, 0, 0));
    check_b("reset_b", mk(R_NONE, 32'h0, 32'h0, 32'h4, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (va[i]) run_vec(1'b0, i, va[i]);
    foreach (vb[i]) run_vec(1'b1, i, vb[i]);

    // Asynchronous reset between edges: state must clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst_a", mk(R_NONE, 32'h0, 32'h0, 32'h4, 0, 0));
    check_b("async_rst_b", mk(R_NONE, 32'h0, 32'h0, 32'h4, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation resumes after reset; ret on the cleared stack is an error again.
    run_vec(1'b0, 100, mk(R_STEP, 32'h0, 32'h4, 32'h8, 0, 0));
    run_vec(1'b1, 100, mk(R_RET,  32'h0, 32'h0, 32'h4, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no summary, required finish before 50000ns");
    $fatal(1);
  end

endmodule
